rca_operand_collector: RTL
==========================

// Module: rca_operand_collector
// PURPOSE
//  Parametrised successor to the fixed five-operand rca_inputs_t bundle. Assembles NUM_OPERANDS
//  operands for an RCA instruction over several beats from a READ_PORTS-wide register-file read.
//  Queues complete packets in an in-order FIFO and dispatches each to its selected RCA over a
//  per-RCA valid/ready handshake. Sits between issue/regfile read and the RCA units.
// PARAMETERS
//  XLEN         32  operand width
//  NUM_OPERANDS 5   operands per RCA instruction (>=1)
//  READ_PORTS   2   operands delivered per input beat (>=1)
//  NUM_RCAS     3   number of RCA targets (>=1)
//  FIFO_DEPTH   4   queued complete packets (power of 2, >=2)
//  ID_W         3   instruction id width (matches $clog2(MAX_IDS))
//  Derived: BEATS = ceil(NUM_OPERANDS/READ_PORTS); SEL_W = max(1,$clog2(NUM_RCAS))
// PORTS
//  clk        in  1                 clock
//  rst        in  1                 synchronous active-high reset
//  flush      in  1                 sync clear of partial packet and FIFO
//  in_valid   in  1                 input beat valid
//  in_ready   out 1                 input beat accepted when in_valid&in_ready
//  in_ops     in  READ_PORTS*XLEN   beat operands; slot k = operand beat*READ_PORTS+k
//  in_rca_sel in  SEL_W             target RCA; sampled on beat 0 only
//  in_id      in  ID_W              instruction id; sampled on beat 0 only
//  out_valid  out NUM_RCAS          one-hot; only bit [head.rca_sel] may be set
//  out_ready  in  NUM_RCAS          per-RCA ready
//  out_ops    out NUM_OPERANDS*XLEN head operands, operand 0 in LSBs
//  out_id     out ID_W              head id
//  sel_err    out 1                 1-cycle pulse: packet with rca_sel>=NUM_RCAS dropped
//  occupancy  out $clog2(FIFO_DEPTH)+1  FIFO entries held
// BEHAVIOUR
//  - Reset/flush: beat_cnt=0, FIFO empty; out_valid=0, sel_err=0, occupancy=0, out_ops/out_id=0.
//    flush mid-packet discards beats already taken; input on the flush cycle is ignored.
//  - Assembly FSM: GATHER_0 (beat_cnt=0) -> GATHER_k on each accepted beat; the beat at
//    beat_cnt=BEATS-1 is FINAL and returns to GATHER_0. BEATS=1: every beat is FINAL.
//  - in_ready: 1 on non-final beats; on FINAL beat = !full | pop_this_cycle (push/pop same
//    cycle when full allowed). in_ready=0 during rst/flush.
//  - FINAL beat accept pushes {ops,sel,id}; slots beyond NUM_OPERANDS in last beat ignored.
//  - Pop: out_valid[sel] & out_ready[sel]; other RCAs' ready ignored (strict in-order, a stalled
//    target blocks later packets for other targets).
//  - Latency: FINAL beat accepted cycle N -> out_valid cycle N+1 (registered FIFO).
//  - rca_sel>=NUM_RCAS on FINAL: not pushed, sel_err=1 in cycle N+1, in_ready as normal.
//  - Pointers wrap modulo FIFO_DEPTH; occupancy = push - pop each cycle; never exceeds FIFO_DEPTH.
//  - in_valid low mid-packet: FSM holds beat_cnt indefinitely.
// CONFIGURATION
//  RCA_COLLECTOR_BYPASS_EN defined: when FIFO empty and out_ready[in_rca_sel_latched]=1, the
//    FINAL beat is presented combinationally the same cycle (out_valid in cycle N), not written
//    to FIFO; in_ready on FINAL beat then also 1. If target not ready, normal push path.
//  Undefined: no bypass; fixed 1-cycle latency; no comb path in_* -> out_*.
// TESTING
//  1. Defaults; 3 beats ops {1,2},{3,4},{5,x} sel=1 id=2, out_ready=3'b111 -> cycle after
//     beat 3: out_valid=3'b010, out_ops={5,4,3,2,1}, out_id=2, one cycle, occupancy 1->0.
//  2. out_ready=0; push 4 packets -> occupancy=4, in_ready=0 on 5th FINAL beat; raise
//     out_ready[sel] -> 5th accepted same cycle as pop, occupancy stays 4.
//  3. Packets sel=0 then sel=2, out_ready=3'b100 -> out_valid=3'b001 held, sel=2 never shown
//     until out_ready[0]=1; then order 0 then 2.
//  4. flush after 2 of 3 beats, then new full packet id=5 -> only id=5 dispatched, ops correct.
//  5. sel=3 (NUM_RCAS=3) -> sel_err pulses once, occupancy stays 0, out_valid stays 0.
//  6. BYPASS_EN, empty FIFO, target ready -> out_valid same cycle as FINAL beat, occupancy 0;
//     without macro -> one cycle later.

Source files
------------

// File: rtl/rca_operand_collector.sv
// Multi-beat operand collector: gathers NUM_OPERANDS operands from READ_PORTS-wide beats,
// queues packets in order and dispatches each to its RCA. Optional: RCA_COLLECTOR_BYPASS_EN.
//
// state          | meaning
// GATHER_0       | beat_cnt=0, waiting for beat 0 (captures rca_sel / id)
// GATHER_k       | beat_cnt=k, intermediate beat k of the packet
// GATHER_BEATS-1 | final beat: push to FIFO (or bypass), return to GATHER_0
module rca_operand_collector #(
  parameter int XLEN         = 32,
  parameter int NUM_OPERANDS = 5,
  parameter int READ_PORTS   = 2,
  parameter int NUM_RCAS     = 3,
  parameter int FIFO_DEPTH   = 4,
  parameter int ID_W         = 3,
  localparam int BEATS = (NUM_OPERANDS + READ_PORTS - 1) / READ_PORTS,
  localparam int SEL_W = (NUM_RCAS > 1) ? $clog2(NUM_RCAS) : 1,
  localparam int OCC_W = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [READ_PORTS*XLEN-1:0]   in_ops,
  input  logic [SEL_W-1:0]             in_rca_sel,
  input  logic [ID_W-1:0]              in_id,
  output logic [NUM_RCAS-1:0]          out_valid,
  input  logic [NUM_RCAS-1:0]          out_ready,
  output logic [NUM_OPERANDS*XLEN-1:0] out_ops,
  output logic [ID_W-1:0]              out_id,
  output logic                         sel_err,
  output logic [OCC_W-1:0]             occupancy
);

  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int RDY_W  = 1 << SEL_W;

  logic [BEAT_W-1:0] beat_cnt, beat_nxt;
  logic              blk, is_final, accept, sel_ok, push, pop, full, empty;
  logic              bypass_ok, bypass_fire;
  logic [SEL_W-1:0]  sel_lat, sel_cur, head_sel;
  logic [ID_W-1:0]   id_lat, id_cur;
  logic [RDY_W-1:0]  rdy_pad;

  logic [XLEN-1:0]              ops_buf [NUM_OPERANDS];
  logic [NUM_OPERANDS*XLEN-1:0] pkt_ops;

  logic [NUM_OPERANDS*XLEN-1:0] mem_ops [FIFO_DEPTH];
  logic [SEL_W-1:0]             mem_sel [FIFO_DEPTH];
  logic [ID_W-1:0]              mem_id  [FIFO_DEPTH];
  logic [PTR_W-1:0]             wr_ptr, rd_ptr;
  logic [OCC_W-1:0]             count;
  logic                         sel_err_q;

  assign blk      = rst | flush;
  assign is_final = (beat_cnt == BEAT_W'(BEATS - 1));
  assign accept   = in_valid & in_ready;
  assign sel_cur  = (beat_cnt == '0) ? in_rca_sel : sel_lat;
  assign id_cur   = (beat_cnt == '0) ? in_id : id_lat;
  assign sel_ok   = 32'(sel_cur) < NUM_RCAS;
  assign rdy_pad  = RDY_W'(out_ready);
  assign full     = (count == OCC_W'(FIFO_DEPTH));
  assign empty    = (count == '0);
  assign head_sel = mem_sel[rd_ptr];
  assign pop      = !empty && !blk && rdy_pad[head_sel];

`ifdef RCA_COLLECTOR_BYPASS_EN
  logic tgt_ready;
  assign tgt_ready   = rdy_pad[sel_cur];
  assign bypass_ok   = !blk && is_final && sel_ok && empty && tgt_ready;
  assign bypass_fire = bypass_ok && in_valid;
`else
  assign bypass_ok   = 1'b0;
  assign bypass_fire = 1'b0;
`endif

  assign push = accept && is_final && sel_ok && !bypass_fire;

  always_ff @(posedge clk) begin
    if (rst) beat_cnt <= '0;
    else     beat_cnt <= beat_nxt;
  end

  always_comb begin
    beat_nxt = beat_cnt;
    if (flush)       beat_nxt = '0;
    else if (accept) beat_nxt = is_final ? '0 : beat_cnt + BEAT_W'(1);
  end

  // Final beat may share a cycle with a pop, so a full FIFO does not stall it then.
  always_comb begin
    in_ready = 1'b0;
    if (!blk) in_ready = is_final ? (!full || pop || bypass_ok) : 1'b1;
  end

  always_comb begin
    pkt_ops = '0;
    for (int i = 0; i < NUM_OPERANDS; i++) begin
      if (i / READ_PORTS == BEATS - 1)
        pkt_ops[i*XLEN +: XLEN] = in_ops[(i % READ_PORTS)*XLEN +: XLEN];
      else
        pkt_ops[i*XLEN +: XLEN] = ops_buf[i];
    end
  end

  always_ff @(posedge clk) begin
    if (accept && beat_cnt == '0) begin
      sel_lat <= in_rca_sel;
      id_lat  <= in_id;
    end
    for (int i = 0; i < NUM_OPERANDS; i++) begin
      if (accept && int'(beat_cnt) == i / READ_PORTS)
        ops_buf[i] <= in_ops[(i % READ_PORTS)*XLEN +: XLEN];
    end
  end

  always_ff @(posedge clk) begin
    if (blk) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      sel_err_q <= 1'b0;
    end else begin
      sel_err_q <= accept && is_final && !sel_ok;
      if (push) begin
        mem_ops[wr_ptr] <= pkt_ops;
        mem_sel[wr_ptr] <= sel_cur;
        mem_id[wr_ptr]  <= id_cur;
        wr_ptr          <= wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + OCC_W'(push) - OCC_W'(pop);
    end
  end

  always_comb begin
    out_valid = '0;
    out_ops   = '0;
    out_id    = '0;
    if (bypass_fire) begin
      out_valid = NUM_RCAS'(1) << sel_cur;
      out_ops   = pkt_ops;
      out_id    = id_cur;
    end else if (!empty && !blk) begin
      out_valid = NUM_RCAS'(1) << head_sel;
      out_ops   = mem_ops[rd_ptr];
      out_id    = mem_id[rd_ptr];
    end
  end

  assign sel_err   = sel_err_q;
  assign occupancy = count;

endmodule
